// File: rtl/decimal_number_entry_pkg.sv
// Shared constants and state encoding for the decimal keypad entry front end.
// The downstream classifier bench reuses the default hold/gap timing from here.
package decimal_number_entry_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int DIGIT_MAX = 9;
    localparam int NUM_MAX   = 255;

    // Hold must outlast the classifier's slowest case (255 down the mod-3 path, ~90 cycles).
    localparam int HOLD_CYCLES_DEF = 96;
    localparam int GAP_CYCLES_DEF  = 4;
    localparam int MAX_DIGITS_DEF  = 3;

endpackage

// File: rtl/decimal_number_entry_digit_mac.sv
// Combinational acc*10+digit using shifts and adds, with a flag when the result exceeds 8 bits.
// 10-bit datapath: the top only consults it while acc <= 99, so the sum never wraps.
module digit_mac
    import decimal_number_entry_pkg::*;
(
    input  logic [7:0] i_acc,
    input  logic [3:0] i_digit,
    output logic [7:0] o_sum,
    output logic       o_ovf
);

    logic [9:0] w_acc_wide;
    logic [9:0] w_prod;

    assign w_acc_wide = {2'b00, i_acc};
    assign w_prod     = (w_acc_wide << 3) + (w_acc_wide << 1) + {6'd0, i_digit};
    assign o_sum      = w_prod[7:0];
    assign o_ovf      = (w_prod > 10'(NUM_MAX));

endmodule

// File: rtl/decimal_number_entry.sv
// Keypad digit accumulator: builds an 8-bit value from up to three BCD digits, then
// presents it to the classifier for a fixed hold window followed by a zero gap.
module decimal_number_entry
    import decimal_number_entry_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int MAX_DIGITS  = MAX_DIGITS_DEF
)
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_digit_valid,
    input  logic [3:0] i_digit,
    input  logic       i_enter,
    input  logic       i_clear,
    output logic [7:0] o_number,
    output logic       o_number_valid,
    output logic       o_busy,
    output logic       o_overflow,
    output logic [1:0] o_digit_count
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 256) begin : g_bad_hold
        $error("HOLD_CYCLES must be in 1..256");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 256) begin : g_bad_gap
        $error("GAP_CYCLES must be in 1..256");
    end
    if (MAX_DIGITS < 1 || MAX_DIGITS > 3) begin : g_bad_digits
        $error("MAX_DIGITS must be in 1..3");
    end

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);
    localparam logic [1:0] CNT_LIMIT = 2'(MAX_DIGITS);

    state_t     r_state;
    logic [7:0] r_acc;
    logic [1:0] r_cnt;
    logic       r_ovf;
    logic [7:0] r_number;
    logic       r_number_valid;
    logic       r_busy;
    logic [7:0] r_timer;

    logic [7:0] w_sum;
    logic       w_mac_ovf;
    logic       w_digit_ok;

    digit_mac u_digit_mac (
        .i_acc   (r_acc),
        .i_digit (i_digit),
        .o_sum   (w_sum),
        .o_ovf   (w_mac_ovf)
    );

    // Out-of-range digits and digits past the limit are dropped without touching overflow.
    assign w_digit_ok = (i_digit <= 4'(DIGIT_MAX)) && (r_cnt < CNT_LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_acc          <= 8'd0;
            r_cnt          <= 2'd0;
            r_ovf          <= 1'b0;
            r_number       <= 8'd0;
            r_number_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_timer        <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    if (i_clear) begin
                        r_acc   <= 8'd0;
                        r_cnt   <= 2'd0;
                        r_ovf   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (i_enter) begin
                        if (r_state == ST_ACCUM) begin
                            if (r_acc != 8'd0) begin
                                r_number       <= r_acc;
                                r_number_valid <= 1'b1;
                                r_busy         <= 1'b1;
                                r_timer        <= HOLD_LOAD;
                                r_state        <= ST_HOLD;
                            end else begin
                                // A zero entry is never shown: the classifier ignores 0 anyway.
                                r_acc   <= 8'd0;
                                r_cnt   <= 2'd0;
                                r_state <= ST_IDLE;
                            end
                        end
                    end else if (i_digit_valid && w_digit_ok) begin
                        if (w_mac_ovf) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_acc   <= w_sum;
                            r_cnt   <= r_cnt + 2'd1;
                            r_state <= ST_ACCUM;
                        end
                    end
                end

                ST_HOLD: begin
                    if (i_clear) begin
                        r_number       <= 8'd0;
                        r_number_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_acc          <= 8'd0;
                        r_cnt          <= 2'd0;
                        r_ovf          <= 1'b0;
                        r_state        <= ST_IDLE;
                    end else if (r_timer == 8'd0) begin
                        r_number       <= 8'd0;
                        r_number_valid <= 1'b0;
                        r_timer        <= GAP_LOAD;
                        r_state        <= ST_GAP;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end

                ST_GAP: begin
                    if (i_clear) begin
                        r_number       <= 8'd0;
                        r_number_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_acc          <= 8'd0;
                        r_cnt          <= 2'd0;
                        r_ovf          <= 1'b0;
                        r_state        <= ST_IDLE;
                    end else if (r_timer == 8'd0) begin
                        r_busy  <= 1'b0;
                        r_acc   <= 8'd0;
                        r_cnt   <= 2'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_number       = r_number;
    assign o_number_valid = r_number_valid;
    assign o_busy         = r_busy;
    assign o_overflow     = r_ovf;
    assign o_digit_count  = r_cnt;

endmodule
